// File: rtl/universal_shift_unit.sv
// Parametrised shift register with load, logical/arithmetic shifts and rotates,
// executing an N-bit shift one bit per cycle behind a start/busy/done handshake.
module universal_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_left,
    input  logic             ser_in_right,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out_left,
    output logic             ser_out_right,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_ASR  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Fill bits are taken live on every shift edge so chained units see each other's current output.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input op_e              o,
        input logic             fill_left,
        input logic             fill_right
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (o)
            OP_SHR:  r = {fill_left, d[WIDTH-1:1]};
            OP_SHL:  r = {d[WIDTH-2:0], fill_right};
            OP_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROR:  r = {d[0], d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // done is a pulse: it falls on every edge that does not explicitly raise it, even while frozen.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op_e'(op))
                            OP_LOAD: begin
                                data_d = par_in;
                                done_d = 1'b1;
                            end
                            OP_SHR, OP_SHL, OP_ASR, OP_ROR, OP_ROL: begin
                                if (amount == '0) begin
                                    done_d = 1'b1;
                                end else begin
                                    op_d    = op_e'(op);
                                    count_d = amount;
                                    state_d = SHIFT;
                                    busy_d  = 1'b1;
                                end
                            end
                            default: done_d = 1'b1;
                        endcase
                    end
                end
                SHIFT: begin
                    data_d  = shift_step(data_q, op_q, ser_in_left, ser_in_right);
                    count_d = count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_out      = data_q;
    assign ser_out_left  = data_q[WIDTH-1];
    assign ser_out_right = data_q[0];
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_universal_shift_unit.sv
// Directed scoreboard bench for universal_shift_unit at WIDTH=8: each expected
// cycle is queued as stimulus is driven and popped one clock later.
module tb_universal_shift_unit;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       start;
    logic [2:0] op;
    logic [3:0] amount;
    logic [7:0] par_in;
    logic       ser_in_left;
    logic       ser_in_right;
    logic [7:0] data_out;
    logic       ser_out_left;
    logic       ser_out_right;
    logic       busy;
    logic       done;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   compared;
    int   mismatched;

    logic [7:0] rol_vals [8] = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
    logic [7:0] asr_vals [9] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFF};

    universal_shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .start         (start),
        .op            (op),
        .amount        (amount),
        .par_in        (par_in),
        .ser_in_left   (ser_in_left),
        .ser_in_right  (ser_in_right),
        .data_out      (data_out),
        .ser_out_left  (ser_out_left),
        .ser_out_right (ser_out_right),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [3:0] a, input logic [7:0] p);
        start  = s;
        op     = o;
        amount = a;
        par_in = p;
    endtask

    task automatic expectCycle(input string tag, input logic [7:0] d, input logic b, input logic dn);
        exp_t e;
        e.tag  = tag;
        e.data = d;
        e.busy = b;
        e.done = dn;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        compared++;
        assert (sb_q.size() > 0) else begin
            mismatched++;
            $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            compared++;
            assert (data_out === e.data) else begin
                mismatched++;
                $error("[TB] FAIL %s.data observed=%h expected=%h", e.tag, data_out, e.data);
            end
            compared++;
            assert (busy === e.busy) else begin
                mismatched++;
                $error("[TB] FAIL %s.busy observed=%b expected=%b", e.tag, busy, e.busy);
            end
            compared++;
            assert (done === e.done) else begin
                mismatched++;
                $error("[TB] FAIL %s.done observed=%b expected=%b", e.tag, done, e.done);
            end
            compared++;
            assert (ser_out_left === e.data[7]) else begin
                mismatched++;
                $error("[TB] FAIL %s.ser_out_left observed=%b expected=%b", e.tag, ser_out_left, e.data[7]);
            end
            compared++;
            assert (ser_out_right === e.data[0]) else begin
                mismatched++;
                $error("[TB] FAIL %s.ser_out_right observed=%b expected=%b", e.tag, ser_out_right, e.data[0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic doLoad(input logic [7:0] v);
        applyStimulus(1'b1, 3'b001, 4'd0, v);
        expectCycle("load", v, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        expectCycle("load_settle", v, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        reset        = 1'b1;
        enable       = 1'b1;
        ser_in_left  = 1'b0;
        ser_in_right = 1'b0;
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        #2;
        expectCycle("reset", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        doLoad(8'h5B);

        $display("[TB] SHR by 3 with left fill 1");
        ser_in_left = 1'b1;
        applyStimulus(1'b1, 3'b010, 4'd3, 8'h00);
        expectCycle("shr_accept", 8'h5B, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        expectCycle("shr_1", 8'hAD, 1'b1, 1'b0);
        tick();
        expectCycle("shr_2", 8'hD6, 1'b1, 1'b0);
        tick();
        expectCycle("shr_3", 8'hEB, 1'b0, 1'b1);
        tick();
        expectCycle("shr_idle", 8'hEB, 1'b0, 1'b0);
        tick();
        ser_in_left = 1'b0;

        $display("[TB] ASR by 2");
        doLoad(8'h96);
        applyStimulus(1'b1, 3'b100, 4'd2, 8'h00);
        expectCycle("asr_accept", 8'h96, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        expectCycle("asr_1", 8'hCB, 1'b1, 1'b0);
        tick();
        expectCycle("asr_2", 8'hE5, 1'b0, 1'b1);
        tick();

        $display("[TB] ROL by 8");
        doLoad(8'hA5);
        applyStimulus(1'b1, 3'b110, 4'd8, 8'h00);
        expectCycle("rol_accept", 8'hA5, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            expectCycle("rol_step", rol_vals[i], (i != 7), (i == 7));
            tick();
        end

        $display("[TB] ROR by 1");
        doLoad(8'h01);
        applyStimulus(1'b1, 3'b101, 4'd1, 8'h00);
        expectCycle("ror_accept", 8'h01, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        expectCycle("ror_1", 8'h80, 1'b0, 1'b1);
        tick();

        $display("[TB] SHL by 4 with stall and ignored start");
        doLoad(8'h0F);
        ser_in_right = 1'b0;
        applyStimulus(1'b1, 3'b011, 4'd4, 8'h00);
        expectCycle("shl_accept", 8'h0F, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 3'b001, 4'd2, 8'hFF);
        expectCycle("shl_1_start_ignored", 8'h1E, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        expectCycle("shl_2", 8'h3C, 1'b1, 1'b0);
        tick();
        enable = 1'b0;
        expectCycle("shl_stall_1", 8'h3C, 1'b1, 1'b0);
        tick();
        expectCycle("shl_stall_2", 8'h3C, 1'b1, 1'b0);
        tick();
        enable = 1'b1;
        expectCycle("shl_3", 8'h78, 1'b1, 1'b0);
        tick();
        expectCycle("shl_4", 8'hF0, 1'b0, 1'b1);
        tick();
        expectCycle("shl_idle", 8'hF0, 1'b0, 1'b0);
        tick();

        $display("[TB] ROR by 5 aborted by reset");
        doLoad(8'h81);
        applyStimulus(1'b1, 3'b101, 4'd5, 8'h00);
        expectCycle("abort_accept", 8'h81, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        expectCycle("abort_1", 8'hC0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        expectCycle("abort_reset", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expectCycle("abort_no_done", 8'h00, 1'b0, 1'b0);
            tick();
        end

        $display("[TB] ASR by 9 exceeds width");
        doLoad(8'h80);
        applyStimulus(1'b1, 3'b100, 4'd9, 8'h00);
        expectCycle("asr9_accept", 8'h80, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            expectCycle("asr9_step", asr_vals[i], (i != 8), (i == 8));
            tick();
        end

        $display("[TB] zero amount, reserved, NOP, load on done, frozen idle");
        doLoad(8'h3C);
        applyStimulus(1'b1, 3'b011, 4'd0, 8'h00);
        expectCycle("shl_zero", 8'h3C, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 3'b111, 4'd3, 8'hAA);
        expectCycle("reserved", 8'h3C, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 3'b000, 4'd3, 8'hAA);
        expectCycle("nop", 8'h3C, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 3'b001, 4'd0, 8'h77);
        expectCycle("load_on_done", 8'h77, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        expectCycle("load_on_done_settle", 8'h77, 1'b0, 1'b0);
        tick();
        enable = 1'b0;
        applyStimulus(1'b1, 3'b001, 4'd0, 8'h11);
        expectCycle("frozen_idle_start", 8'h77, 1'b0, 1'b0);
        tick();
        enable = 1'b1;
        applyStimulus(1'b0, 3'b000, 4'd0, 8'h00);
        expectCycle("frozen_idle_after", 8'h77, 1'b0, 1'b0);
        tick();

        compared++;
        assert (sb_q.size() == 0) else begin
            mismatched++;
            $error("[TB] FAIL scoreboard_drain observed=%0d entries expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
